// File: rtl/htif_mem_loader.sv
// HTIF loader: decodes host WRITE/READ/RELEASE word streams into word-wide scratchpad requests.
// Define HTIF_LOADER_CSUM_EN to return a per-burst wrap-around checksum after every WRITE.
module htif_mem_loader #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_in_valid,
  output logic          host_in_ready,
  input  logic [31:0]   host_in_data,
  output logic          host_out_valid,
  input  logic          host_out_ready,
  output logic [31:0]   host_out_data,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_fcn,
  output logic [2:0]    mem_req_typ,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_data,
  input  logic [DW-1:0] mem_resp_data,
  output logic          core_reset
);

  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam logic [7:0] OP_RELEASE = 8'h03;

`ifdef HTIF_LOADER_CSUM_EN
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;
`endif

  state_t          state_q, state_d;
  logic            core_reset_q, core_reset_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_data_q, out_data_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            op_write_q, op_write_d;
`ifdef HTIF_LOADER_CSUM_EN
  logic [31:0]     sum_q, sum_d;
`endif
  logic            rd_go;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^host_in_data[1:0];

  assign mem_req_typ  = 3'd2;
  assign mem_req_addr = addr_q;
  assign core_reset   = core_reset_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      core_reset_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      count_q      <= '0;
      addr_q       <= '0;
      op_write_q   <= 1'b0;
`ifdef HTIF_LOADER_CSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      core_reset_q <= core_reset_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      count_q      <= count_d;
      addr_q       <= addr_d;
      op_write_q   <= op_write_d;
`ifdef HTIF_LOADER_CSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    core_reset_d   = core_reset_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    count_d        = count_q;
    addr_d         = addr_q;
    op_write_d     = op_write_q;
`ifdef HTIF_LOADER_CSUM_EN
    sum_d          = sum_q;
`endif
    host_in_ready  = 1'b0;
    host_out_valid = out_valid_q;
    host_out_data  = out_data_q;
    mem_req_valid  = 1'b0;
    mem_req_fcn    = 1'b0;
    mem_req_data   = '0;
    rd_go          = 1'b0;

    // A drained output register empties unless a read reloads it below.
    if (out_valid_q && host_out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        host_in_ready = 1'b1;
        if (host_in_valid) begin
          case (host_in_data[31:24])
            OP_WRITE, OP_READ: begin
`ifdef HTIF_LOADER_CSUM_EN
              if (host_in_data[31:24] == OP_WRITE) sum_d = '0;
`endif
              if (host_in_data[CW-1:0] != '0) begin
                count_d    = host_in_data[CW-1:0];
                op_write_d = (host_in_data[31:24] == OP_WRITE);
                state_d    = ADDR;
              end
            end
            OP_RELEASE: core_reset_d = 1'b0;
            default: ;
          endcase
        end
      end
      ADDR: begin
        host_in_ready = 1'b1;
        if (host_in_valid) begin
          addr_d  = {host_in_data[AW-1:2], 2'b00};
          state_d = op_write_q ? WDATA : RDATA;
        end
      end
      WDATA: begin
        mem_req_valid = host_in_valid;
        host_in_ready = mem_req_ready;
        mem_req_fcn   = 1'b1;
        mem_req_data  = host_in_data;
        if (host_in_valid && mem_req_ready) begin
          addr_d  = addr_q + AW'(4);
          count_d = count_q - CW'(1);
`ifdef HTIF_LOADER_CSUM_EN
          sum_d   = sum_q + host_in_data;
          if (count_q == CW'(1)) state_d = CSUM;
`else
          if (count_q == CW'(1)) state_d = IDLE;
`endif
        end
      end
      RDATA: begin
        // Only fetch when the single output slot is free or being drained this cycle.
        rd_go         = !out_valid_q || host_out_ready;
        mem_req_valid = rd_go;
        if (rd_go && mem_req_ready) begin
          out_data_d  = mem_resp_data;
          out_valid_d = 1'b1;
          addr_d      = addr_q + AW'(4);
          count_d     = count_q - CW'(1);
          if (count_q == CW'(1)) state_d = IDLE;
        end
      end
`ifdef HTIF_LOADER_CSUM_EN
      CSUM: begin
        // Any read word still pending goes out ahead of the checksum.
        host_out_valid = 1'b1;
        host_out_data  = out_valid_q ? out_data_q : sum_q;
        if (host_out_ready && !out_valid_q) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_htif_mem_loader.sv
// Directed bench for htif_mem_loader: per-cycle vector table plus reset/checksum sequences.
// Checksum vectors are included only when HTIF_LOADER_CSUM_EN is defined.
module tb_htif_mem_loader;

  logic        clk;
  logic        rst;
  logic        host_in_valid;
  logic        host_in_ready;
  logic [31:0] host_in_data;
  logic        host_out_valid;
  logic        host_out_ready;
  logic [31:0] host_out_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_fcn;
  logic [2:0]  mem_req_typ;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [31:0] mem_resp_data;
  logic        core_reset;

  int checks = 0;
  int errors = 0;
  int readCount = 0;

  logic [31:0] mem [256];

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        mr;
    logic        orr;
    logic        eIr;
    logic        eRv;
    logic        eFcn;
    logic [31:0] eAddr;
    logic        eOv;
    logic [31:0] eOd;
    logic        eCr;
  } vec_t;

  vec_t vecs[$];

  htif_mem_loader #(.AW(32), .DW(32), .CW(24)) dut (
    .clk            (clk),
    .rst            (rst),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_in_data   (host_in_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .host_out_data  (host_out_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_fcn    (mem_req_fcn),
    .mem_req_typ    (mem_req_typ),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_resp_data  (mem_resp_data),
    .core_reset     (core_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratchpad model: combinational read, write on the clock edge of an accepted write request.
  assign mem_resp_data = mem[mem_req_addr[9:2]];

  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) begin
      if (mem_req_fcn) mem[mem_req_addr[9:2]] <= mem_req_data;
      else readCount <= readCount + 1;
    end
  end

  function automatic vec_t mkVec(input logic iv, input logic [31:0] id, input logic mr,
                                 input logic orr, input logic eIr, input logic eRv,
                                 input logic eFcn, input logic [31:0] eAddr, input logic eOv,
                                 input logic [31:0] eOd, input logic eCr);
    vec_t v;
    v.iv = iv; v.id = id; v.mr = mr; v.orr = orr;
    v.eIr = eIr; v.eRv = eRv; v.eFcn = eFcn; v.eAddr = eAddr;
    v.eOv = eOv; v.eOd = eOd; v.eCr = eCr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    host_in_valid  = v.iv;
    host_in_data   = v.id;
    mem_req_ready  = v.mr;
    host_out_ready = v.orr;
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    check({tag, ".in_ready"},   32'(host_in_ready),  32'(v.eIr));
    check({tag, ".req_valid"},  32'(mem_req_valid),  32'(v.eRv));
    if (v.eRv) begin
      check({tag, ".req_fcn"},  32'(mem_req_fcn),    32'(v.eFcn));
      check({tag, ".req_addr"}, mem_req_addr,        v.eAddr);
      check({tag, ".req_typ"},  32'(mem_req_typ),    32'd2);
      if (v.eFcn) check({tag, ".req_data"}, mem_req_data, v.id);
    end
    check({tag, ".out_valid"},  32'(host_out_valid), 32'(v.eOv));
    check({tag, ".out_data"},   host_out_data,       v.eOd);
    check({tag, ".core_reset"}, 32'(core_reset),     32'(v.eCr));
  endtask

  task automatic runVec(input vec_t v, input string tag);
    applyStimulus(v);
    checkOutput(v, tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst = 1'b1;
    host_in_valid = 1'b0;
    host_in_data = 32'h0;
    mem_req_ready = 1'b1;
    host_out_ready = 1'b1;

    // WRITE 3 words at 0x102 (masked to 0x100) with one idle and one stalled cycle
    vecs.push_back(mkVec(1, 32'h01000003, 1, 1, 1, 0, 0, 32'h0,        0, 32'h0, 1));
    vecs.push_back(mkVec(1, 32'h00000102, 1, 1, 1, 0, 0, 32'h0,        0, 32'h0, 1));
    vecs.push_back(mkVec(1, 32'h11111111, 1, 1, 1, 1, 1, 32'h00000100, 0, 32'h0, 1));
    vecs.push_back(mkVec(0, 32'h00000000, 1, 1, 1, 0, 0, 32'h0,        0, 32'h0, 1));
    vecs.push_back(mkVec(1, 32'h22222222, 0, 1, 0, 1, 1, 32'h00000104, 0, 32'h0, 1));
    vecs.push_back(mkVec(1, 32'h22222222, 1, 1, 1, 1, 1, 32'h00000104, 0, 32'h0, 1));
    vecs.push_back(mkVec(1, 32'h33333333, 1, 1, 1, 1, 1, 32'h00000108, 0, 32'h0, 1));
`ifdef HTIF_LOADER_CSUM_EN
    vecs.push_back(mkVec(0, 32'h00000000, 1, 1, 0, 0, 0, 32'h0,        1, 32'h66666666, 1));
`endif
    vecs.push_back(mkVec(0, 32'h00000000, 1, 1, 1, 0, 0, 32'h0,        0, 32'h0, 1));
    // READ 3 words at 0x100 with host_out_ready 1,0,1,1
    vecs.push_back(mkVec(1, 32'h02000003, 1, 1, 1, 0, 0, 32'h0,        0, 32'h0, 1));
    vecs.push_back(mkVec(1, 32'h00000100, 1, 1, 1, 0, 0, 32'h0,        0, 32'h0, 1));
    vecs.push_back(mkVec(0, 32'h00000000, 1, 1, 0, 1, 0, 32'h00000100, 0, 32'h0, 1));
    vecs.push_back(mkVec(0, 32'h00000000, 1, 0, 0, 0, 0, 32'h0,        1, 32'h11111111, 1));
    vecs.push_back(mkVec(0, 32'h00000000, 1, 1, 0, 1, 0, 32'h00000104, 1, 32'h11111111, 1));
    vecs.push_back(mkVec(0, 32'h00000000, 1, 1, 0, 1, 0, 32'h00000108, 1, 32'h22222222, 1));
    vecs.push_back(mkVec(0, 32'h00000000, 1, 1, 1, 0, 0, 32'h0,        1, 32'h33333333, 1));
    vecs.push_back(mkVec(0, 32'h00000000, 1, 0, 1, 0, 0, 32'h0,        0, 32'h33333333, 1));
    // RELEASE, then an unknown opcode and two words that must also be treated as headers
    vecs.push_back(mkVec(1, 32'h03000000, 1, 1, 1, 0, 0, 32'h0,        0, 32'h33333333, 1));
    vecs.push_back(mkVec(1, 32'h7F000005, 1, 1, 1, 0, 0, 32'h0,        0, 32'h33333333, 0));
    vecs.push_back(mkVec(1, 32'h00000200, 1, 1, 1, 0, 0, 32'h0,        0, 32'h33333333, 0));
    vecs.push_back(mkVec(1, 32'hAAAAAAAA, 1, 1, 1, 0, 0, 32'h0,        0, 32'h33333333, 0));
    // WRITE with N=0 is consumed without leaving IDLE
    vecs.push_back(mkVec(1, 32'h01000000, 1, 1, 1, 0, 0, 32'h0,        0, 32'h33333333, 0));
    vecs.push_back(mkVec(1, 32'h00000300, 1, 1, 1, 0, 0, 32'h0,        0, 32'h33333333, 0));
    vecs.push_back(mkVec(1, 32'h55555555, 1, 1, 1, 0, 0, 32'h0,        0, 32'h33333333, 0));
    // WRITE 2 words starting at the top of the address space; address wraps to 0
    vecs.push_back(mkVec(1, 32'h01000002, 1, 1, 1, 0, 0, 32'h0,        0, 32'h33333333, 0));
    vecs.push_back(mkVec(1, 32'hFFFFFFFF, 1, 1, 1, 0, 0, 32'h0,        0, 32'h33333333, 0));
    vecs.push_back(mkVec(1, 32'h12345678, 1, 1, 1, 1, 1, 32'hFFFFFFFC, 0, 32'h33333333, 0));
    vecs.push_back(mkVec(1, 32'h9ABCDEF0, 1, 1, 1, 1, 1, 32'h00000000, 0, 32'h33333333, 0));
`ifdef HTIF_LOADER_CSUM_EN
    vecs.push_back(mkVec(0, 32'h00000000, 1, 1, 0, 0, 0, 32'h0,        1, 32'hACF13568, 0));
`endif
    vecs.push_back(mkVec(0, 32'h00000000, 1, 1, 1, 0, 0, 32'h0,        0, 32'h33333333, 0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset: core held, no traffic
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("idle%0d.core_reset", i), 32'(core_reset),     32'd1);
      check($sformatf("idle%0d.out_valid", i),  32'(host_out_valid), 32'd0);
      check($sformatf("idle%0d.req_valid", i),  32'(mem_req_valid),  32'd0);
    end

    for (int i = 0; i < vecs.size(); i++) runVec(vecs[i], $sformatf("vec%0d", i));

    check("mem.0x100", mem[64],  32'h11111111);
    check("mem.0x104", mem[65],  32'h22222222);
    check("mem.0x108", mem[66],  32'h33333333);
    check("mem.0xFFFFFFFC", mem[255], 32'h12345678);
    check("mem.0x0",   mem[0],   32'h9ABCDEF0);
    check("read_count", 32'(readCount), 32'd3);

    // Reset in the middle of a 3-word WRITE, after the first word
    runVec(mkVec(1, 32'h01000003, 1, 1, 1, 0, 0, 32'h0,        0, 32'h33333333, 0), "rst.hdr");
    runVec(mkVec(1, 32'h00000200, 1, 1, 1, 0, 0, 32'h0,        0, 32'h33333333, 0), "rst.addr");
    runVec(mkVec(1, 32'hDEADBEEF, 1, 1, 1, 1, 1, 32'h00000200, 0, 32'h33333333, 0), "rst.w0");
    @(negedge clk);
    host_in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst.async.core_reset", 32'(core_reset),     32'd1);
    check("rst.async.out_valid",  32'(host_out_valid), 32'd0);
    check("rst.async.out_data",   host_out_data,       32'h0);
    check("rst.async.req_valid",  32'(mem_req_valid),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    runVec(mkVec(1, 32'h01000001, 1, 1, 1, 0, 0, 32'h0,        0, 32'h0, 1), "post.hdr");
    runVec(mkVec(1, 32'h00000300, 1, 1, 1, 0, 0, 32'h0,        0, 32'h0, 1), "post.addr");
    runVec(mkVec(1, 32'hCAFEF00D, 1, 1, 1, 1, 1, 32'h00000300, 0, 32'h0, 1), "post.w0");
`ifdef HTIF_LOADER_CSUM_EN
    runVec(mkVec(0, 32'h00000000, 1, 1, 0, 0, 0, 32'h0,        1, 32'hCAFEF00D, 1), "post.csum");
`endif
    runVec(mkVec(0, 32'h00000000, 1, 1, 1, 0, 0, 32'h0,        0, 32'h0, 1), "post.idle");
    check("mem.0x200", mem[128], 32'hDEADBEEF);
    check("mem.0x300", mem[192], 32'hCAFEF00D);

`ifdef HTIF_LOADER_CSUM_EN
    // Checksum wraps modulo 2^32 and holds while the host stalls
    runVec(mkVec(1, 32'h01000002, 1, 1, 1, 0, 0, 32'h0,        0, 32'h0, 1), "csum.hdr");
    runVec(mkVec(1, 32'h00000400, 1, 1, 1, 0, 0, 32'h0,        0, 32'h0, 1), "csum.addr");
    runVec(mkVec(1, 32'hFFFFFFFF, 1, 1, 1, 1, 1, 32'h00000400, 0, 32'h0, 1), "csum.w0");
    runVec(mkVec(1, 32'h00000002, 1, 1, 1, 1, 1, 32'h00000404, 0, 32'h0, 1), "csum.w1");
    runVec(mkVec(0, 32'h00000000, 1, 0, 0, 0, 0, 32'h0,        1, 32'h00000001, 1), "csum.hold");
    runVec(mkVec(0, 32'h00000000, 1, 1, 0, 0, 0, 32'h0,        1, 32'h00000001, 1), "csum.take");
    runVec(mkVec(0, 32'h00000000, 1, 1, 1, 0, 0, 32'h0,        0, 32'h0, 1), "csum.idle");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/htif_mem_loader.md
Name: htif_mem_loader

Overview:
- Host-target interface (HTIF) loader that sits directly upstream of the scratchpad memory on its data-side request port.
- Accepts a 32-bit word stream from the host, decodes write/read/release commands, and issues word-wide memory requests.
- Returns read data to the host and holds the core in reset until the host releases it.
- Lets the host load a program image at run time.

Parameters:
- AW, 32, memory byte-address width.
- DW, 32, memory data width; fixed at 32 for this block.
- CW, 24, width of the burst word-count field in the command header.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- host_in_valid  in  1  host command/data word valid
- host_in_ready  out  1  loader accepts host_in_data this cycle
- host_in_data  in  32  header, address or write-data word
- host_out_valid  out  1  response word valid
- host_out_ready  in  1  host accepts response word
- host_out_data  out  32  read data (or checksum)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_fcn  out  1  1 = write, 0 = read
- mem_req_typ  out  3  access size; always 3'd2 (word)
- mem_req_addr  out  AW  byte address, bits [1:0] always 0
- mem_req_data  out  DW  write data
- mem_resp_data  in  DW  asynchronous read data, valid in the same cycle as the request
- core_reset  out  1  holds the core in reset; high from reset until the RELEASE command

Behaviour:
- Reset values:
  - state=IDLE, core_reset=1, host_out_valid=0, host_out_data=0, mem_req_valid=0.
  - Count and address registers 0.
  - Reset is asynchronous. Reset mid-burst abandons the burst, drops any pending response and re-asserts core_reset.
- Header word:
  - [31:24] opcode: 8'h01 WRITE, 8'h02 READ, 8'h03 RELEASE.
  - [CW-1:0] word count N.
- IDLE:
  - host_in_ready=1.
  - On a header handshake:
    - WRITE or READ with N!=0: latch N, go to ADDR.
    - WRITE or READ with N==0: consumed, stay in IDLE.
    - RELEASE: core_reset<=0 on the next edge, stay in IDLE.
    - Any other opcode: ignored, stay in IDLE.
- ADDR:
  - host_in_ready=1.
  - On handshake: addr <= {data[AW-1:2],2'b00}.
  - Go to WDATA for WRITE, RDATA for READ.
- WDATA:
  - mem_req_valid=host_in_valid, host_in_ready=mem_req_ready, fcn=1, data=host_in_data.
  - On each accepted word: addr+=4 (wraps modulo 2^AW), count-=1.
  - When count reaches 0: go to IDLE (or CSUM, see Optional Feature).
  - No memory write occurs without a host word.
- RDATA:
  - host_in_ready=0.
  - mem_req_valid=1, fcn=0, only when the output register is empty or being drained (host_out_valid==0 or host_out_ready==1).
  - On a request handshake: host_out_data<=mem_resp_data, host_out_valid<=1, addr+=4, count-=1.
  - Last word issued: go to IDLE.
  - host_out_valid clears on an output handshake with no new load.
  - Back-to-back reads sustain 1 word/cycle while host_out_ready=1.
  - If host_out_ready stays low, host_out_data holds.
- Timing: one-word output register, so read latency is 1 cycle from memory request to host_out_valid.
- Header acceptance: while host_out_valid is pending after a burst, IDLE still accepts headers, but a new READ does not overwrite the register until it drains.
- Ordering: core_reset is unaffected by WRITE/READ. The host may read or write memory after RELEASE; this block does not arbitrate against the core.

Optional Feature:
- Macro: HTIF_LOADER_CSUM_EN.
- Defined:
  - After the final WRITE word, enter CSUM.
  - In CSUM: present host_out_valid=1 with host_out_data = 32-bit wrap-around sum of all data words of that burst.
  - Return to IDLE on the output handshake.
  - host_in_ready=0 while in CSUM.
  - The sum clears on each WRITE header.
- Undefined: WRITE produces no response, no CSUM state and no sum register.

Test Plan:
- Reset, then no stimulus -> core_reset=1, host_out_valid=0, mem_req_valid=0 for 10 cycles.
- Stream 0x01000003, 0x00000102, 0x11111111, 0x22222222, 0x33333333 with mem_req_ready=1 -> three writes at addresses 0x100, 0x104, 0x108 (low address bits masked), typ=2, fcn=1; back in IDLE.
- Stream 0x02000003, 0x00000100 with host_out_ready toggling 1,0,1,1 -> returns 0x11111111, 0x22222222, 0x33333333 in order, data held stable while ready=0, no extra memory reads.
- Header 0x03000000 -> core_reset drops on the next edge. Then header 0x7F000005 -> ignored, state stays IDLE.
- Assert rst mid-WRITE after 1 of 3 words -> core_reset=1, IDLE. The next 0x01000001 header is decoded as a fresh header.
- With HTIF_LOADER_CSUM_EN: WRITE N=2 of 0xFFFFFFFF, 0x00000002 -> host_out_data=0x00000001.
